// File: rtl/t03_sync_decoder_pkg.sv
// Shared timing constants and decoder state type for the display sync path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t03_sync_pkg;

   // Line/frame geometry, shared with the horizontal timing generator.
   localparam int H_TOTAL = 209;
   localparam int V_TOTAL = 525;

   // Output counter widths.
   localparam int HCNT_W = 11;
   localparam int VCNT_W = 10;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } sync_state_t;

endpackage

// File: rtl/t03_sync_decoder_if.sv
// Sync inputs and recovered-timing outputs of the sync decoder.
// Latency: n/a (wires only).
// Backpressure: none; outputs are free-running status/pulses.
// master: drives hsync_in/vsync_in, observes timing outputs.
// slave : the decoder; consumes syncs, drives hcnt/vcnt/pulses/locked/line_len/err.
interface t03_sync_decoder_if;
   import t03_sync_pkg::*;

   logic              hsync_in;
   logic              vsync_in;
   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   logic              line_start;
   logic              frame_start;
   logic              locked;
   logic [HCNT_W-1:0] line_len;
   logic              err;

   modport master (
      output hsync_in, vsync_in,
      input  hcnt, vcnt, line_start, frame_start, locked, line_len, err
   );

   modport slave (
      input  hsync_in, vsync_in,
      output hcnt, vcnt, line_start, frame_start, locked, line_len, err
   );
endinterface

// File: rtl/t03_sync_decoder_edge_detect.sv
// Leading-edge detector for one sync line with selectable active polarity.
// Latency: combinational edge_out in the cycle the active level first appears.
// Backpressure: none.
// Ports: clk, nrst (sync, active-low), sig_in (raw sync), edge_out (leading edge).
module t03_sync_edge_detect #(
   parameter bit SYNC_POL = 1'b1
) (
   input  logic clk,
   input  logic nrst,
   input  logic sig_in,
   output logic edge_out
);

   logic hist_q;

   // History resets to the asserted level so a pulse held through reset
   // release is not mistaken for a fresh edge.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         hist_q <= SYNC_POL;
      end else begin
         hist_q <= sig_in;
      end
   end

   assign edge_out = (sig_in == SYNC_POL) && (hist_q != SYNC_POL);

endmodule

// File: rtl/t03_sync_decoder.sv
// Recovers pixel position from hsync/vsync, measures line period, tracks lock.
// Latency: one cycle from a sync leading edge to counters/pulses/state.
// Backpressure: none; outputs update every cycle.
// Ports: clk, nrst (sync, active-low); bus (slave): hsync_in/vsync_in in,
//        hcnt, vcnt, line_start, frame_start, locked, line_len, err out.
module t03_sync_decoder #(
   parameter int H_TOTAL    = t03_sync_pkg::H_TOTAL,
   parameter int LOCK_LINES = 4,
   parameter bit SYNC_POL   = 1'b1
) (
   input  logic              clk,
   input  logic              nrst,
   t03_sync_decoder_if.slave bus
);
   import t03_sync_pkg::*;

   localparam int                MC_W       = $clog2(LOCK_LINES + 1);
   localparam logic [HCNT_W-1:0] H_TOTAL_W  = HCNT_W'(H_TOTAL);
   localparam logic [HCNT_W-1:0] TIMEOUT_AT = HCNT_W'(2 * H_TOTAL - 1);

   sync_state_t       state_q, state_d;
   logic [MC_W-1:0]   match_q, match_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [VCNT_W-1:0] vcnt_q, vcnt_d;
   logic [HCNT_W-1:0] line_len_q, line_len_d;
   logic              line_start_q, line_start_d;
   logic              frame_start_q, frame_start_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;

   logic              hs_edge, vs_edge;
   logic [HCNT_W-1:0] hcnt_inc;
   logic              timeout;

   t03_sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
      .clk      (clk),
      .nrst     (nrst),
      .sig_in   (bus.hsync_in),
      .edge_out (hs_edge)
   );

   t03_sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
      .clk      (clk),
      .nrst     (nrst),
      .sig_in   (bus.vsync_in),
      .edge_out (vs_edge)
   );

   // Saturating increment; hcnt+1 is also the measured period at an edge.
   assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + 1'b1;

   // Two full lines without an hsync edge means the source has gone away.
   assign timeout = (state_q != SEARCH) && (hcnt_q == TIMEOUT_AT);

   always_comb begin
      state_d       = state_q;
      match_d       = match_q;
      hcnt_d        = hcnt_inc;
      vcnt_d        = vcnt_q;
      line_len_d    = line_len_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      err_d         = 1'b0;

      if (hs_edge) begin
         hcnt_d       = '0;
         line_len_d   = hcnt_inc;
         line_start_d = 1'b1;
         vcnt_d       = (&vcnt_q) ? vcnt_q : vcnt_q + 1'b1;
         case (state_q)
            SEARCH: begin
               state_d = MEASURE;
               match_d = '0;
            end
            MEASURE: begin
               if (hcnt_inc == H_TOTAL_W) begin
                  match_d = match_q + 1'b1;
                  if (int'(match_q) + 1 >= LOCK_LINES) begin
                     state_d = LOCKED;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               if (hcnt_inc != H_TOTAL_W) begin
                  state_d = MEASURE;
                  match_d = '0;
                  err_d   = 1'b1;
               end
            end
            default: begin
               state_d = SEARCH;
               match_d = '0;
            end
         endcase
      end else if (timeout) begin
         state_d = SEARCH;
         match_d = '0;
         err_d   = (state_q == LOCKED);
      end

      // A frame start only clears the line number; horizontal phase is
      // owned by hsync alone.
      if (vs_edge) begin
         vcnt_d        = '0;
         frame_start_d = 1'b1;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q       <= SEARCH;
         match_q       <= '0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         line_len_q    <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         match_q       <= match_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         line_len_q    <= line_len_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         err_q         <= err_d;
      end
   end

   assign bus.hcnt        = hcnt_q;
   assign bus.vcnt        = vcnt_q;
   assign bus.line_len    = line_len_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.locked      = locked_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_t03_sync_decoder.sv
// Bench for t03_sync_decoder: active-high and active-low builds run side by side.
// Latency: expected outputs are queued at stimulus time, checked one clock later.
// Backpressure: none.
module tb_t03_sync_decoder;
   import t03_sync_pkg::*;

   localparam int H_LINE  = 209;
   localparam int LOCK_N  = 4;
   localparam int TMO     = 2 * H_LINE - 1;
   localparam int H_SAT   = 2047;
   localparam int V_SAT   = 1023;

   typedef struct packed {
      logic [HCNT_W-1:0] hcnt;
      logic [VCNT_W-1:0] vcnt;
      logic              ls;
      logic              fs;
      logic              locked;
      logic [HCNT_W-1:0] line_len;
      logic              err;
   } obs_t;

   logic clk = 1'b0;
   logic nrst;

   t03_sync_decoder_if bus_p ();
   t03_sync_decoder_if bus_n ();

   t03_sync_decoder #(.H_TOTAL(H_LINE), .LOCK_LINES(LOCK_N), .SYNC_POL(1'b1)) dut_p (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus_p)
   );

   t03_sync_decoder #(.H_TOTAL(H_LINE), .LOCK_LINES(LOCK_N), .SYNC_POL(1'b0)) dut_n (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus_n)
   );

   always #5 clk = ~clk;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: "since" is cycles elapsed since the last line start,
   // "run" is how many good periods followed the first edge seen.
   bit m_prev_hs, m_prev_vs, m_have_ref;
   int m_since, m_run, m_len, m_vcnt;

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_step(input bit r, input bit hs, input bit vs);
      obs_t e;
      bit   hs_e, vs_e, was_locked;
      int   per;
      e = '0;
      if (!r) begin
         m_prev_hs = 1'b1; m_prev_vs = 1'b1; m_have_ref = 1'b0;
         m_since = 0; m_run = 0; m_len = 0; m_vcnt = 0;
      end else begin
         hs_e = hs && !m_prev_hs;
         vs_e = vs && !m_prev_vs;
         m_prev_hs = hs;
         m_prev_vs = vs;
         was_locked = m_have_ref && (m_run >= LOCK_N);
         if (hs_e) begin
            per     = min2(m_since + 1, H_SAT);
            m_len   = per;
            m_since = 0;
            m_vcnt  = min2(m_vcnt + 1, V_SAT);
            if (!m_have_ref) begin
               m_have_ref = 1'b1;
               m_run      = 0;
            end else if (per == H_LINE) begin
               m_run = m_run + 1;
            end else begin
               m_run = 0;
               e.err = was_locked;
            end
         end else begin
            if (m_have_ref && m_since == TMO) begin
               m_have_ref = 1'b0;
               m_run      = 0;
               e.err      = was_locked;
            end
            m_since = m_since + 1;
         end
         if (vs_e) m_vcnt = 0;
         e.hcnt     = HCNT_W'(min2(m_since, H_SAT));
         e.vcnt     = VCNT_W'(m_vcnt);
         e.ls       = hs_e;
         e.fs       = vs_e;
         e.locked   = m_have_ref && (m_run >= LOCK_N);
         e.line_len = HCNT_W'(m_len);
      end
      exp_q.push_back(e);
   endtask

   // hs/vs are "active" flags; the low-polarity build sees them inverted.
   task automatic drive(input bit r, input bit hs, input bit vs);
      @(negedge clk);
      nrst           = r;
      bus_p.hsync_in = hs;
      bus_p.vsync_in = vs;
      bus_n.hsync_in = !hs;
      bus_n.vsync_in = !vs;
      model_step(r, hs, vs);
   endtask

   // One line: hsync active for 'width' cycles at the start; optional
   // 3-cycle vsync pulse starting at cycle vs_at (0 = coincident with hsync).
   task automatic line(input int period, input int width, input int vs_at);
      for (int i = 0; i < period; i++)
         drive(1'b1, i < width, (vs_at >= 0) && (i >= vs_at) && (i < vs_at + 3));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input obs_t act, input obs_t e);
      n_checks++;
      if (act !== e) begin
         n_errors++;
         $display("FAIL %s t=%0t got hcnt=%0d vcnt=%0d ls=%b fs=%b lk=%b len=%0d err=%b want hcnt=%0d vcnt=%0d ls=%b fs=%b lk=%b len=%0d err=%b",
                  name, $time, act.hcnt, act.vcnt, act.ls, act.fs, act.locked, act.line_len, act.err,
                  e.hcnt, e.vcnt, e.ls, e.fs, e.locked, e.line_len, e.err);
      end
   endtask

   // Monitor: pops one expectation per clock once stimulus has started.
   initial begin : monitor
      obs_t e, ap, an;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ap = {bus_p.hcnt, bus_p.vcnt, bus_p.line_start, bus_p.frame_start,
                  bus_p.locked, bus_p.line_len, bus_p.err};
            an = {bus_n.hcnt, bus_n.vcnt, bus_n.line_start, bus_n.frame_start,
                  bus_n.locked, bus_n.line_len, bus_n.err};
            check("pol_hi", ap, e);
            check("pol_lo", an, e);
         end
      end
   end

   initial begin : stimulus
      int r, per, w, va;
      nrst           = 1'b0;
      bus_p.hsync_in = 1'b0;
      bus_p.vsync_in = 1'b0;
      bus_n.hsync_in = 1'b1;
      bus_n.vsync_in = 1'b1;

      // Reset state, then lock onto nominal lines.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
      idle(5);
      for (int i = 0; i < 7; i++) line(H_LINE, 8, -1);

      // One short line breaks lock, then it recovers.
      line(208, 8, -1);
      for (int i = 0; i < 6; i++) line(H_LINE, 8, -1);

      // hsync disappears: timeout, then hcnt saturation.
      line(2200, 8, -1);

      // Relock, frame start coincident with a line start, then vsync mid-line.
      for (int i = 0; i < 6; i++) line(H_LINE, 8, -1);
      line(H_LINE, 8, 0);
      line(H_LINE, 8, 100);
      line(H_LINE, 8, -1);

      // Reset mid-pulse while locked, hsync still active across release.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
      idle(50);
      for (int i = 0; i < 7; i++) line(H_LINE, 8, -1);

      // Randomized line periods, pulse widths, vsync placement and resets.
      for (int n = 0; n < 50; n++) begin
         r  = $urandom_range(0, 9);
         w  = $urandom_range(1, 16);
         va = -1;
         if (r <= 5)      per = H_LINE;
         else if (r == 6) per = 208;
         else if (r == 7) per = 210;
         else if (r == 8) per = $urandom_range(20, 600);
         else begin
            per = H_LINE;
            for (int i = 0; i < 2; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            idle(3);
         end
         if ($urandom_range(0, 5) == 0) va = $urandom_range(0, per - 4);
         line(per, w, va);
      end

      idle(2);
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
